score_text_renderer: RTL
========================

Name: score_text_renderer

Overview:
- Downstream consumer of the score/lives character RAM in the HUD path.
- Converts the VGA beam position into a character-RAM read address, then fetches the glyph row from an external 8x16 font ROM.
- Outputs a registered per-pixel text_on flag and colour for the colour mapper.
- Pipelined so the character RAM's 1-cycle read latency and the font ROM's 1-cycle read latency line up exactly with the delayed beam position.

Parameters:
- TEXT_X0, 0, left pixel edge of the text window.
- TEXT_Y0, 0, top pixel edge of the text window.
- COLS, 80, characters per text row (8 px each).
- ROWS, 2, text rows (16 px each); COLS*ROWS must be <= 160.
- FG_RGB, 24'hFFFF00, foreground colour for lit text pixels.

Ports:
- Clk  input  1  system clock; all state on rising edge.
- Reset  input  1  synchronous, active-high reset.
- pix_en  input  1  pixel strobe; the pipeline advances only when 1.
- DrawX  input  10  current beam X; held stable while pix_en=0.
- DrawY  input  10  current beam Y; held stable while pix_en=0.
- vsync  input  1  frame sync, active-low pulse.
- read_address  output  8  character-RAM read address (combinational).
- char_data  input  8  character-RAM data, valid 1 clock after read_address.
- font_addr  output  11  {char_code[6:0], glyph_row[3:0]} to font ROM (combinational).
- font_data  input  8  font ROM row, valid 1 clock after font_addr; bit 7 is the leftmost pixel.
- text_on  output  1  registered: current delayed pixel is lit text.
- text_rgb  output  24  registered colour; FG_RGB when text_on, else 0.
- frame_cnt  output  8  free-running frame counter.

Behaviour:
- Reset values: text_on=0, text_rgb=0, frame_cnt=0, all pipeline valid bits 0.
- Window check: in_win = (DrawX-TEXT_X0 < COLS*8) && (DrawY-TEXT_Y0 < ROWS*16).
  - Subtraction is 11-bit unsigned, so coordinates left of or above the origin wrap high and fail the check.
- Address generation (combinational):
  - col = (DrawX-TEXT_X0)>>3, row = (DrawY-TEXT_Y0)>>4.
  - read_address = row*COLS+col, truncated to 8 bits.
  - Outside the window, read_address = 0.
- Stage 1, on Clk edge with pix_en=1:
  - Register v1=in_win, glyph_row=(DrawY-TEXT_Y0)[3:0], bit1=(DrawX-TEXT_X0)[2:0].
  - The character RAM latches char_data on the same edge.
- font_addr = {char_data[6:0], glyph_row}, combinational from char_data and stage-1 registers.
- Stage 2, on pix_en edge: register v2=v1, bit2=bit1. The font ROM latches font_data on the same edge.
- Stage 3, on pix_en edge:
  - text_on <= v2 && font_data[7-bit2].
  - text_rgb <= text_on_next ? FG_RGB : 0.
- Latency: text_on corresponds to the DrawX/DrawY presented 3 pix_en strobes earlier. The colour mapper delays sprite paths to match.
- pix_en=0: every pipeline register holds its value.
  - Because DrawX/DrawY are held, RAM and ROM outputs stay valid across gaps of any length.
- Character code 8'h00 maps to the blank glyph (font ROM row data 0), so text_on=0.
- frame_cnt: increments on each vsync falling edge, detected with a registered vsync sample; it wraps 255->0.
- Reset asserted mid-line: pipeline valid bits clear the next edge. text_on is 0 for at least 3 pix_en strobes after Reset deasserts.

Optional Feature:
- Macro: SCORE_TEXT_BLINK_EN.
- Defined:
  - char_data[7] marks a blinking character; the glyph still uses bits [6:0].
  - Stage 1 registers blink1=char_data[7] one edge later, aligned with font_addr; it pipes to blink2.
  - Stage 3 forces text_on=0 when blink2 && frame_cnt[5]. This gives a 32-frame on / 32-frame off blink.
- Undefined: bit 7 is ignored, no blink logic is built, and frame_cnt is still present.

Test Plan:
- Reset held 4 clocks with pix_en=1 and a lit pixel in the window -> text_on=0, text_rgb=0, frame_cnt=0 throughout, and for 3 strobes after release.
- DrawX=56, DrawY=5 (col 7, row 0) -> read_address=7. Model returns char_data=8'h31 and font_data=8'h80 -> text_on=1, text_rgb=FG_RGB exactly 3 strobes later.
- DrawX=300, DrawY=20 -> read_address=117. DrawX=700 -> read_address=0, and text_on=0 regardless of font_data.
- pix_en toggling 1,0,0,0,1 with a held beam -> outputs change only on pix_en edges, with 3-strobe latency preserved.
- Score-RAM model holding "Score:123" with a scan across row 0 -> lit-pixel pattern matches the font model for chars 0..9; char 8'h00 is never lit.
- Apply 64 vsync pulses with SCORE_TEXT_BLINK_EN defined and char_data=8'hB2:
  - Pixel is lit during frames 0..31 and dark during frames 32..63.
  - Without the macro, the same stimulus keeps the pixel lit for all 64 frames.

Source files
------------

// File: rtl/score_text_renderer_if.sv
// Beam-in / glyph-out bundle between the HUD timing, char RAM, font ROM and the text renderer.
// The renderer takes the slave modport; the surrounding logic (or a bench) takes master.
interface score_text_renderer_if;
  logic        pix_en;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        vsync;
  logic [7:0]  read_address;
  logic [7:0]  char_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        text_on;
  logic [23:0] text_rgb;
  logic [7:0]  frame_cnt;

  modport slave (
    input  pix_en, DrawX, DrawY, vsync, char_data, font_data,
    output read_address, font_addr, text_on, text_rgb, frame_cnt
  );

  modport master (
    output pix_en, DrawX, DrawY, vsync, char_data, font_data,
    input  read_address, font_addr, text_on, text_rgb, frame_cnt
  );
endinterface

// File: rtl/score_text_renderer.sv
// HUD text renderer: beam -> char RAM address -> font ROM row -> registered text pixel, 3 pix_en strobes of latency.
// Optional blinking characters via `define SCORE_TEXT_BLINK_EN (char_data[7] marks blink, gated by frame_cnt[5]).
module score_text_renderer #(
  parameter int          TEXT_X0 = 0,
  parameter int          TEXT_Y0 = 0,
  parameter int          COLS    = 80,
  parameter int          ROWS    = 2,
  parameter logic [23:0] FG_RGB  = 24'hFFFF00
) (
  input  logic                  Clk,
  input  logic                  Reset,
  score_text_renderer_if.slave  bus
);

  localparam logic [31:0] WIN_W  = 32'(COLS * 8);
  localparam logic [31:0] WIN_H  = 32'(ROWS * 16);
  localparam logic [15:0] COLS_W = 16'(COLS);

  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_win;
  logic [15:0] addr_full;

  logic        v1;
  logic [3:0]  glyph_row;
  logic [2:0]  bit1;
  logic        v2;
  logic [2:0]  bit2;
  logic        text_on_q;
  logic [23:0] text_rgb_q;
  logic        text_on_next;

  logic        vsync_q;
  logic [7:0]  frame_cnt_q;

  // Unsigned 11-bit offsets: beam left of / above the origin wraps high and falls out of the window.
  always_comb begin
    dx        = {1'b0, bus.DrawX} - 11'(TEXT_X0);
    dy        = {1'b0, bus.DrawY} - 11'(TEXT_Y0);
    in_win    = ({21'd0, dx} < WIN_W) && ({21'd0, dy} < WIN_H);
    addr_full = ({9'd0, dy[10:4]} * COLS_W) + {8'd0, dx[10:3]};
  end

  assign bus.read_address = in_win ? addr_full[7:0] : 8'd0;
  assign bus.font_addr    = {bus.char_data[6:0], glyph_row};

`ifdef SCORE_TEXT_BLINK_EN
  logic blink1;
  logic blink2;

  // char_data is the RAM's output register, so it already sits beside font_addr as stage 1.
  assign blink1 = bus.char_data[7];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      blink2 <= 1'b0;
    end else if (bus.pix_en) begin
      blink2 <= blink1;
    end
  end

  always_comb begin
    text_on_next = v2 && bus.font_data[3'd7 - bit2] && !(blink2 && frame_cnt_q[5]);
  end
`else
  logic unused_blink;
  assign unused_blink = bus.char_data[7];

  always_comb begin
    text_on_next = v2 && bus.font_data[3'd7 - bit2];
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1         <= 1'b0;
      glyph_row  <= 4'd0;
      bit1       <= 3'd0;
      v2         <= 1'b0;
      bit2       <= 3'd0;
      text_on_q  <= 1'b0;
      text_rgb_q <= 24'd0;
    end else if (bus.pix_en) begin
      v1         <= in_win;
      glyph_row  <= dy[3:0];
      bit1       <= dx[2:0];
      v2         <= v1;
      bit2       <= bit1;
      text_on_q  <= text_on_next;
      text_rgb_q <= text_on_next ? FG_RGB : 24'd0;
    end
  end

  // Frame counter runs every clock, independent of the pixel strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vsync_q     <= 1'b1;
      frame_cnt_q <= 8'd0;
    end else begin
      vsync_q <= bus.vsync;
      if (vsync_q && !bus.vsync) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign bus.text_on   = text_on_q;
  assign bus.text_rgb  = text_rgb_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule
